// File: rtl/icache_responder_pkg.sv
// Shared types for the direct-mapped instruction cache: address split,
// frame layout and fill-FSM states.
package icache_responder_pkg;

    localparam int unsigned ICACHE_SETS  = 8;
    localparam int unsigned ICACHE_IDX_W = $clog2(ICACHE_SETS);
    localparam int unsigned ICACHE_TAG_W = 32 - ICACHE_IDX_W - 3;

    typedef logic [31:0] word_t;

    typedef struct packed {
        logic [ICACHE_TAG_W-1:0] tag;
        logic [ICACHE_IDX_W-1:0] idx;
        logic                    blkoff;
        logic [1:0]              bytoff;
    } icachef_t;

    typedef struct packed {
        logic                    valid;
        logic [ICACHE_TAG_W-1:0] tag;
        word_t [1:0]             data;
    } icache_frame_t;

    typedef enum logic [1:0] {
        IDLE,
        FILL0,
        FILL1
    } icache_state_t;

endpackage

// File: rtl/icache_responder.sv
// Direct-mapped read-only instruction cache: same-cycle hits, 2-word block
// fill from the memory controller on a miss.
module icache_responder
    import icache_responder_pkg::*;
#(
    parameter int unsigned SETS      = ICACHE_SETS,
    parameter int unsigned BLK_WORDS = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    input  logic        halt,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload,
    output logic [31:0] miss_count
);

    localparam int unsigned IDX_W = ICACHE_IDX_W;

    if (BLK_WORDS != 2 || SETS != ICACHE_SETS) begin : g_bad_cfg
        $error("icache_responder: BLK_WORDS must be 2 and SETS must match the package");
    end

    icache_state_t          r_state;
    icache_frame_t          r_frames [SETS];
    logic [31-3:0]          r_miss_addr;
    logic [31:0]            r_miss_count;

    icachef_t               w_addr;
    icache_frame_t          w_frame;
    logic                   w_hit;
    logic [IDX_W-1:0]       w_fill_idx;
    logic [ICACHE_TAG_W-1:0] w_fill_tag;
    logic                   w_unused;

    assign w_addr     = icachef_t'(imemaddr);
    assign w_frame    = r_frames[w_addr.idx];
    assign w_fill_idx = r_miss_addr[IDX_W-1:0];
    assign w_fill_tag = r_miss_addr[31-3:IDX_W];
    assign w_unused   = ^w_addr.bytoff;

    // Hits are only served from IDLE, which keeps ihit and iREN exclusive.
    assign w_hit = (r_state == IDLE) && imemREN && w_frame.valid
                   && (w_frame.tag == w_addr.tag);

    always_comb begin
        ihit     = w_hit;
        imemload = '0;
        if (w_hit) begin
            imemload = w_frame.data[w_addr.blkoff];
        end
    end

    always_comb begin
        iREN  = 1'b0;
        iaddr = '0;
        case (r_state)
            FILL0: begin
                iREN  = 1'b1;
                iaddr = {r_miss_addr, 1'b0, 2'b00};
            end
            FILL1: begin
                iREN  = 1'b1;
                iaddr = {r_miss_addr, 1'b1, 2'b00};
            end
            default: ;
        endcase
    end

    assign miss_count = r_miss_count;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state      <= IDLE;
            r_miss_addr  <= '0;
            r_miss_count <= '0;
            for (int unsigned i = 0; i < SETS; i++) begin
                r_frames[i] <= '0;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    // Invalidate the victim up front so a half-filled frame never hits.
                    if (imemREN && !w_hit && !halt) begin
                        r_miss_addr                 <= {w_addr.tag, w_addr.idx};
                        r_frames[w_addr.idx].valid  <= 1'b0;
                        r_state                     <= FILL0;
                    end
                end
                FILL0: begin
                    if (!iwait) begin
                        r_frames[w_fill_idx].data[0] <= iload;
                        r_state                      <= FILL1;
                    end
                end
                FILL1: begin
                    if (!iwait) begin
                        r_frames[w_fill_idx].data[1] <= iload;
                        r_frames[w_fill_idx].tag     <= w_fill_tag;
                        r_frames[w_fill_idx].valid   <= 1'b1;
                        if (r_miss_count != '1) begin
                            r_miss_count <= r_miss_count + 32'd1;
                        end
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_icache_responder.sv
// Directed bench for icache_responder with a memory model that stalls each
// requested word for two cycles.
module tb_icache_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        halt;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic [31:0] miss_count;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [1:0] wait_cnt = '0;

    always #5 clk = ~clk;

    icache_responder #(.SETS(8), .BLK_WORDS(2)) dut (
        .CLK        (clk),
        .RST        (rst),
        .imemREN    (imemREN),
        .imemaddr   (imemaddr),
        .halt       (halt),
        .ihit       (ihit),
        .imemload   (imemload),
        .iREN       (iREN),
        .iaddr      (iaddr),
        .iwait      (iwait),
        .iload      (iload),
        .miss_count (miss_count)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0040: return 32'h2001_0005;
            32'h0000_0044: return 32'h2002_0006;
            default:       return {16'hC0DE, a[15:0]};
        endcase
    endfunction

    // Two wait cycles per requested word, then one cycle of valid data.
    assign iwait = iREN && (wait_cnt < 2'd2);
    assign iload = iREN ? mem_word(iaddr) : 32'h0;

    always @(posedge clk) begin
        if (!iREN || !iwait) wait_cnt <= 2'd0;
        else                 wait_cnt <= wait_cnt + 2'd1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            @(negedge clk);
            #1;
        end
    endtask

    initial begin
        rst = 1'b1; imemREN = 1'b0; imemaddr = '0; halt = 1'b0;
        tick(2);
        rst = 1'b0;
        #1;
        chk("rst_ihit", {31'b0, ihit}, 32'd0);
        chk("rst_iren", {31'b0, iREN}, 32'd0);
        chk("rst_iaddr", iaddr, 32'd0);
        chk("rst_load", imemload, 32'd0);
        chk("rst_cnt", miss_count, 32'd0);

        // Cold miss on 0x40
        imemREN = 1'b1; imemaddr = 32'h40; #1;
        chk("t1_miss", {31'b0, ihit}, 32'd0);
        tick(1);
        chk("t1_iren0", {31'b0, iREN}, 32'd1);
        chk("t1_iaddr0", iaddr, 32'h40);
        chk("t1_nohit", {31'b0, ihit}, 32'd0);
        tick(3);
        chk("t1_iren1", {31'b0, iREN}, 32'd1);
        chk("t1_iaddr1", iaddr, 32'h44);
        tick(3);
        chk("t1_hit", {31'b0, ihit}, 32'd1);
        chk("t1_load", imemload, 32'h2001_0005);
        chk("t1_iren_off", {31'b0, iREN}, 32'd0);
        chk("t1_cnt", miss_count, 32'd1);

        // Spatial hit
        imemaddr = 32'h44; #1;
        chk("t2_hit", {31'b0, ihit}, 32'd1);
        chk("t2_load", imemload, 32'h2002_0006);
        chk("t2_iren", {31'b0, iREN}, 32'd0);

        // Conflict on idx 0
        imemaddr = 32'h80; #1;
        chk("t3_miss", {31'b0, ihit}, 32'd0);
        tick(1);
        chk("t3_iaddr0", iaddr, 32'h80);
        tick(3);
        chk("t3_iaddr1", iaddr, 32'h84);
        tick(3);
        chk("t3_hit", {31'b0, ihit}, 32'd1);
        chk("t3_load", imemload, 32'hC0DE_0080);
        chk("t3_cnt2", miss_count, 32'd2);
        imemaddr = 32'h40; #1;
        chk("t3_evicted", {31'b0, ihit}, 32'd0);
        tick(1);
        chk("t3_iaddr_re", iaddr, 32'h40);
        tick(6);
        chk("t3_rehit", {31'b0, ihit}, 32'd1);
        chk("t3_reload", imemload, 32'h2001_0005);
        chk("t3_cnt3", miss_count, 32'd3);

        // Address change mid-fill
        imemaddr = 32'h100; #1;
        tick(1);
        chk("t4_iaddr0", iaddr, 32'h100);
        imemaddr = 32'h200; imemREN = 1'b0;
        tick(1);
        chk("t4_hold", iaddr, 32'h100);
        tick(2);
        chk("t4_iaddr1", iaddr, 32'h104);
        tick(3);
        chk("t4_idle", {31'b0, iREN}, 32'd0);
        chk("t4_cnt", miss_count, 32'd4);
        imemREN = 1'b1; imemaddr = 32'h100; #1;
        chk("t4_hit", {31'b0, ihit}, 32'd1);
        chk("t4_load", imemload, 32'hC0DE_0100);
        imemaddr = 32'h200; #1;
        chk("t4_other_miss", {31'b0, ihit}, 32'd0);
        imemREN = 1'b0;

        // Reset during FILL1
        imemREN = 1'b1; imemaddr = 32'h08; #1;
        tick(1);
        chk("t5_iaddr0", iaddr, 32'h08);
        tick(3);
        chk("t5_iaddr1", iaddr, 32'h0C);
        rst = 1'b1;
        tick(1);
        chk("t5_iren", {31'b0, iREN}, 32'd0);
        chk("t5_iaddr", iaddr, 32'd0);
        chk("t5_cnt", miss_count, 32'd0);
        rst = 1'b0; #1;
        chk("t5_miss", {31'b0, ihit}, 32'd0);
        imemaddr = 32'h40; #1;
        chk("t5_flushed", {31'b0, ihit}, 32'd0);

        // Halt: fill 0x40 first, then a missing fetch must not start a fill
        tick(7);
        chk("t6_hit_pre", {31'b0, ihit}, 32'd1);
        chk("t6_cnt", miss_count, 32'd1);
        halt = 1'b1; imemaddr = 32'h80;
        for (int k = 0; k < 20; k++) begin
            tick(1);
            chk("t6_halt_iren", {31'b0, iREN}, 32'd0);
        end
        imemaddr = 32'h40; #1;
        chk("t6_hit", {31'b0, ihit}, 32'd1);
        chk("t6_load", imemload, 32'h2001_0005);
        chk("t6_cnt_end", miss_count, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
